prf_mp: RTL and testbench
=========================

# prf_mp

Multi-ported physical register file with per-register ready scoreboard and registered, write-bypassed reads. It is the next generation of the 2R1W PRF: NR read ports, NW writeback ports and NA rename-allocation ports, all parametrised. It sits between rename/dispatch (allocation), the issue queues (ready lookup) and the execution writeback buses. Physical register 0 is hardwired to zero.

## Interface
- XLEN, 64, data width
- PHYS, 64, number of physical registers (power of two, >= 4)
- PW, $clog2(PHYS), physical register index width
- NR, 4, read ports
- NW, 2, write (writeback) ports
- NA, 2, allocation ports
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NR*PW  read index, port i in bits [i*PW +: PW]
- rd_data  out  NR*XLEN  registered read data, port i in bits [i*XLEN +: XLEN]
- rd_rdy  out  NR  registered ready bit of the register read on port i
- wr_en  in  NW  writeback valid per port
- wr_addr  in  NW*PW  writeback index
- wr_data  in  NW*XLEN  writeback data
- alloc_en  in  NA  rename allocation valid per port
- alloc_addr  in  NA*PW  newly allocated destination; its ready bit clears
- wr_conflict  out  1  registered pulse: two or more enabled write ports targeted the same nonzero index in the previous cycle

## Operation
- State: data array PHYS x XLEN (not reset), ready vector PHYS bits, output registers.
- Write: wr_en[j] with wr_addr[j] != 0 writes wr_data[j] and sets ready[wr_addr[j]].
- Same-index multi-write: highest-numbered port wins data; wr_conflict = 1 next cycle.
- Allocation: alloc_en[k] with alloc_addr[k] != 0 clears ready[alloc_addr[k]].
- Allocation and write to same index in same cycle: allocation wins; ready ends 0, data is still written.
- Index 0: writes and allocations ignored; reads return 0 with rd_rdy = 1.
- Read: rd_addr[i] sampled at the edge; rd_data[i]/rd_rdy[i] present from the next cycle until the following edge.
- Any number of read ports may share an index; reads never stall.
- No handshake; every port is accepted in every cycle.

## Timing
- Reset (rst = 1 at an edge): ready vector all 1, rd_data all 0, rd_rdy all 0, wr_conflict 0. Data array is unchanged. Writes and allocations in that cycle are ignored.
- rst deasserted: normal operation from the next edge. Reads in flight during reset are discarded.
- Write latency: data written at edge N is visible through the array to a read sampled at edge N+1.
- Read latency: 1 cycle (address at edge N, data valid after N).
- With bypass, a read sampled at edge N returns the same-cycle write data, using the highest winning port. rd_rdy returns the post-update ready value, so a same-cycle allocation forces 0.
- wr_conflict asserts for exactly one cycle per conflicting cycle.

## Configuration
- PRF_MP_BYPASS_EN defined: same-cycle write->read and ready forwarding as above.
- PRF_MP_BYPASS_EN undefined: rd_data and rd_rdy return pre-edge array and ready contents. A same-cycle write or allocation becomes visible one cycle later. There is no forwarding mux.

## Test plan
- Reset, then read indices 0, 5, 63 -> rd_data 0/X-free output 0, rd_rdy 1/1/1; wr_conflict 0.
- Alloc 7 at cycle 1; write 7 <= 0xDEAD at cycle 3; read 7 at cycles 2 and 4 -> rd_rdy 0 then 1, rd_data 0xDEAD.
- With BYPASS_EN, write 9 <= 0x1234 and read 9 at the same edge -> next cycle rd_data 0x1234, rd_rdy 1. Without it: old data and ready bit, then 0x1234 one cycle later.
- Ports 0 and 1 both write 12 (0xA, 0xB) -> reading 12 returns 0xB; wr_conflict pulses 1 for one cycle.
- Write 0 <= 0xFFFF with alloc 0 -> reading 0 returns 0, rd_rdy 1, wr_conflict 0.
- Alloc 20 and write 20 <= 0x55 in the same cycle, then read 20 -> rd_data 0x55, rd_rdy 0. Then assert rst -> the next read of 20 gives rd_rdy 1.

Source files
------------

// File: rtl/prf_mp.sv
// prf_mp: NR-read/NW-write PRF with ready scoreboard, p0 hardwired to zero; define PRF_MP_BYPASS_EN for same-cycle forwarding
module prf_mp #(
  parameter int XLEN = 64,
  parameter int PHYS = 64,
  parameter int PW   = $clog2(PHYS),
  parameter int NR   = 4,
  parameter int NW   = 2,
  parameter int NA   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NR*PW-1:0]   rd_addr,
  output logic [NR*XLEN-1:0] rd_data,
  output logic [NR-1:0]      rd_rdy,
  input  logic [NW-1:0]      wr_en,
  input  logic [NW*PW-1:0]   wr_addr,
  input  logic [NW*XLEN-1:0] wr_data,
  input  logic [NA-1:0]      alloc_en,
  input  logic [NA*PW-1:0]   alloc_addr,
  output logic               wr_conflict
);
  logic [XLEN-1:0]    mem_q [PHYS];
  logic [PHYS-1:0]    rdy_q, rdy_d;
  logic [NR*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NR-1:0]      rd_rdy_q, rd_rdy_d;
  logic               wr_conflict_q, wr_conflict_d;
  logic [PW-1:0]      ra;
  assign rd_data     = rd_data_q;
  assign rd_rdy      = rd_rdy_q;
  assign wr_conflict = wr_conflict_q;
  // scoreboard update: writebacks set ready, then allocations clear it so allocation wins
  always_comb begin
    rdy_d = rdy_q;
    wr_conflict_d = 1'b0;
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && wr_addr[j*PW +: PW] != '0) rdy_d[wr_addr[j*PW +: PW]] = 1'b1;
    for (int k = 0; k < NA; k++)
      if (alloc_en[k] && alloc_addr[k*PW +: PW] != '0) rdy_d[alloc_addr[k*PW +: PW]] = 1'b0;
    for (int j = 0; j < NW; j++)
      for (int k = j + 1; k < NW; k++)
        if (wr_en[j] && wr_en[k] && wr_addr[j*PW +: PW] == wr_addr[k*PW +: PW] && wr_addr[j*PW +: PW] != '0)
          wr_conflict_d = 1'b1;
  end
  // read mux per port; index 0 overrides everything since its array entry is never written
  always_comb begin
    rd_data_d = '0;
    rd_rdy_d = '0;
    ra = '0;
    for (int i = 0; i < NR; i++) begin
      ra = rd_addr[i*PW +: PW];
      rd_data_d[i*XLEN +: XLEN] = mem_q[ra];
`ifdef PRF_MP_BYPASS_EN
      rd_rdy_d[i] = rdy_d[ra];
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && wr_addr[j*PW +: PW] == ra) rd_data_d[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
`else
      rd_rdy_d[i] = rdy_q[ra];
`endif
      if (ra == '0) begin
        rd_data_d[i*XLEN +: XLEN] = '0;
        rd_rdy_d[i] = 1'b1;
      end
    end
  end
  // ready vector and output registers; reset drops any read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q         <= '1;
      rd_data_q     <= '0;
      rd_rdy_q      <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      rdy_q         <= rdy_d;
      rd_data_q     <= rd_data_d;
      rd_rdy_q      <= rd_rdy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end
  // data array: not reset; later ports overwrite earlier ones on a shared index
  always_ff @(posedge clk) begin
    if (!rst)
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && wr_addr[j*PW +: PW] != '0) mem_q[wr_addr[j*PW +: PW]] <= wr_data[j*XLEN +: XLEN];
  end
endmodule

// File: tb/tb_prf_mp.sv
// tb_prf_mp: directed scoreboard bench for prf_mp (expectations follow PRF_MP_BYPASS_EN)
module tb_prf_mp;
  localparam int XLEN = 64, PHYS = 64, PW = 6, NR = 4, NW = 2, NA = 2;
`ifdef PRF_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    int          port;
    logic        cd;
    logic [63:0] d;
    logic        r;
  } exp_t;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NR*PW-1:0]   rd_addr = '0;
  logic [NR*XLEN-1:0] rd_data;
  logic [NR-1:0]      rd_rdy;
  logic [NW-1:0]      wr_en = '0;
  logic [NW*PW-1:0]   wr_addr = '0;
  logic [NW*XLEN-1:0] wr_data = '0;
  logic [NA-1:0]      alloc_en = '0;
  logic [NA*PW-1:0]   alloc_addr = '0;
  logic               wr_conflict;
  logic [NR-1:0]      rv = '0, rv_q = '0;
  logic               started = 1'b0, chk_q = 1'b0;
  exp_t               rq[$];
  logic               cq[$];
  int                 n_cmp = 0, n_bad = 0;
  prf_mp #(.XLEN(XLEN), .PHYS(PHYS), .NR(NR), .NW(NW), .NA(NA)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_rdy(rd_rdy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .wr_conflict(wr_conflict)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rv_q  <= rv;
    chk_q <= started;
  end
  always @(negedge clk) begin
    if (chk_q) begin
      for (int i = 0; i < NR; i++) begin
        if (rv_q[i]) begin
          if (rq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rd_underflow port %0d: no expectation queued", i);
          end else begin
            exp_t e;
            e = rq.pop_front();
            n_cmp++;
            if (e.port != i || rd_rdy[i] !== e.r) begin
              n_bad++;
              $display("FAIL rd_rdy port %0d (exp port %0d): got %b want %b", i, e.port, rd_rdy[i], e.r);
            end
            if (e.cd) begin
              n_cmp++;
              if (rd_data[i*XLEN +: XLEN] !== e.d) begin
                n_bad++;
                $display("FAIL rd_data port %0d: got %h want %h", i, rd_data[i*XLEN +: XLEN], e.d);
              end
            end
          end
        end
      end
      n_cmp++;
      if (cq.size() == 0) begin
        n_bad++;
        $display("FAIL conflict_underflow: no expectation queued");
      end else begin
        logic c;
        c = cq.pop_front();
        if (wr_conflict !== c) begin
          n_bad++;
          $display("FAIL wr_conflict: got %b want %b", wr_conflict, c);
        end
      end
    end
  end
  task automatic rd(input int p, input logic [PW-1:0] a, input logic cd, input logic [63:0] d, input logic r);
    rd_addr[p*PW +: PW] = a;
    rv[p] = 1'b1;
    rq.push_back('{p, cd, d, r});
  endtask
  task automatic wr(input int j, input logic [PW-1:0] a, input logic [63:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*PW +: PW] = a;
    wr_data[j*XLEN +: XLEN] = d;
  endtask
  task automatic al(input int k, input logic [PW-1:0] a);
    alloc_en[k] = 1'b1;
    alloc_addr[k*PW +: PW] = a;
  endtask
  task automatic tick(input logic c);
    cq.push_back(c);
    @(posedge clk);
    #1;
    wr_en = '0; alloc_en = '0; rv = '0; rst = 1'b0;
  endtask
  initial begin
    @(posedge clk);
    #1;
    started = 1'b1;
    rst = 1'b1;
    for (int p = 0; p < NR; p++) rd(p, 6'd0, 1'b1, 64'h0, 1'b0);
    tick(1'b0);
    rd(0, 6'd0, 1'b1, 64'h0, 1'b1);
    rd(1, 6'd5, 1'b0, 64'h0, 1'b1);
    rd(2, 6'd63, 1'b0, 64'h0, 1'b1);
    al(0, 6'd7);
    rd(3, 6'd7, 1'b0, 64'h0, !BYP);
    tick(1'b0);
    rd(0, 6'd7, 1'b0, 64'h0, 1'b0);
    tick(1'b0);
    wr(0, 6'd7, 64'hDEAD);
    rd(1, 6'd7, BYP, 64'hDEAD, BYP);
    tick(1'b0);
    rd(2, 6'd7, 1'b1, 64'hDEAD, 1'b1);
    tick(1'b0);
    al(1, 6'd9);
    tick(1'b0);
    wr(1, 6'd9, 64'h1234);
    rd(0, 6'd9, BYP, 64'h1234, BYP);
    tick(1'b0);
    rd(0, 6'd9, 1'b1, 64'h1234, 1'b1);
    tick(1'b0);
    wr(0, 6'd12, 64'hA);
    wr(1, 6'd12, 64'hB);
    rd(0, 6'd12, BYP, 64'hB, 1'b1);
    tick(1'b1);
    rd(3, 6'd12, 1'b1, 64'hB, 1'b1);
    tick(1'b0);
    wr(0, 6'd0, 64'hFFFF);
    wr(1, 6'd0, 64'hEEEE);
    al(0, 6'd0);
    rd(1, 6'd0, 1'b1, 64'h0, 1'b1);
    tick(1'b0);
    rd(2, 6'd0, 1'b1, 64'h0, 1'b1);
    tick(1'b0);
    al(1, 6'd20);
    wr(0, 6'd20, 64'h55);
    rd(0, 6'd20, BYP, 64'h55, BYP ? 1'b0 : 1'b1);
    tick(1'b0);
    rd(0, 6'd20, 1'b1, 64'h55, 1'b0);
    rd(1, 6'd20, 1'b1, 64'h55, 1'b0);
    tick(1'b0);
    rst = 1'b1;
    wr(1, 6'd20, 64'h77);
    al(0, 6'd20);
    rd(0, 6'd20, 1'b1, 64'h0, 1'b0);
    tick(1'b0);
    rd(0, 6'd20, 1'b1, 64'h55, 1'b1);
    tick(1'b0);
    wr(0, 6'd30, 64'h1);
    wr(1, 6'd31, 64'h2);
    rd(1, 6'd30, BYP, 64'h1, 1'b1);
    tick(1'b0);
    wr(0, 6'd40, 64'h5);
    wr_addr[PW +: PW] = 6'd40;
    rd(0, 6'd30, 1'b1, 64'h1, 1'b1);
    rd(3, 6'd31, 1'b1, 64'h2, 1'b1);
    tick(1'b0);
    rd(2, 6'd40, 1'b1, 64'h5, 1'b1);
    tick(1'b0);
    started = 1'b0;
    repeat (3) @(posedge clk);
    n_cmp++;
    if (rq.size() != 0 || cq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d reads and %0d conflict checks left, want 0", rq.size(), cq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
